// File: rtl/ram_pkg.sv
// Shared sizing and word type for the single-port RAM and its parent blocks.
package ram_pkg;

    localparam int RAM_DATA_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 16;

    typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;

endpackage : ram_pkg

// File: rtl/async_single_port_ram.sv
// Single-port RAM with a synchronous write and a combinational read.
// A registered reset flag blanks the output and blocks writes; the contents survive reset.
module async_single_port_ram
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    output logic [DATA_WIDTH-1:0] Q
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic rst_d;
    logic rst_q;
    logic wr_en;

    // A write is dropped when reset is present at the edge or still held in rst_q.
    // An unknown write enable evaluates as false in the if below.
    always_comb begin
        rst_d = rst;
        wr_en = write && !rst && !rst_q;
    end

    always_ff @(posedge clk) begin
        rst_q <= rst_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= data;
        end
    end

    always_comb begin
        Q = mem[addr];
        if (rst_q) begin
            Q = '0;
        end
    end

endmodule : async_single_port_ram

// File: tb/tb_async_single_port_ram.sv
// Directed bench for async_single_port_ram. Stimulus queues expected Q values and a
// monitor on the falling edge pops them and compares them against the live output.
module tb_async_single_port_ram;

    logic        clk;
    logic        rst;
    logic [7:0]  data;
    logic [15:0] addr;
    logic        write;
    logic [7:0]  q_w;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       checks_total;
    int       checks_passed;

    async_single_port_ram #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .addr  (addr),
        .write (write),
        .Q     (q_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: Q is combinational, so it is sampled on the falling edge, midway
    // between the stimulus update (just after the rising edge) and the next write edge.
    initial begin
        sb_item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                checks_total++;
                if (q_w !== it.exp) begin
                    $display("FAIL %s: addr=%h Q=%h expected %h", it.name, addr, q_w, it.exp);
                end else begin
                    checks_passed++;
                    $display("ok   %s: addr=%h Q=%h", it.name, addr, q_w);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_q(input logic [7:0] e, input string name);
        sb_item_t it;
        it.exp  = e;
        it.name = name;
        sb_q.push_back(it);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        data  = d;
        write = 1'b1;
        cyc();
        write = 1'b0;
    endtask

    logic [15:0] sweep_addr;
    int          drain;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst   = 1'b1;
        write = 1'b0;
        addr  = 16'h0010;
        data  = 8'h00;

        // Power-up reset: two edges with reset held
        cyc();
        cyc();
        expect_q(8'h00, "reset_q_zero");
        rst = 1'b0;
        cyc();

        // Seed 0x0010, then a reset window with write=1/data=AA must not touch it
        wr(16'h0010, 8'h3C);
        expect_q(8'h3C, "seed_0010");
        rst   = 1'b1;
        write = 1'b1;
        data  = 8'hAA;
        cyc();
        expect_q(8'h00, "rst_forces_zero_1");
        cyc();
        expect_q(8'h00, "rst_forces_zero_2");
        rst   = 1'b0;
        write = 1'b0;
        cyc();
        expect_q(8'h3C, "rst_write_dropped");
        cyc();

        // Simple write then zero-latency read, and an address switch within a cycle
        wr(16'h1234, 8'h5A);
        expect_q(8'h5A, "wr_1234");
        cyc();
        addr = 16'h0010;
        expect_q(8'h3C, "addr_switch_0010");
        cyc();

        // Sweep the low and high address ranges with data = low address byte
        for (int i = 0; i < 1024; i++) begin
            wr(16'(i), 8'(i));
        end
        for (int i = 16'hFF00; i <= 16'hFFFF; i++) begin
            wr(16'(i), 8'(i));
        end
        for (int i = 0; i < 1024; i++) begin
            sweep_addr = 16'(i);
            addr = sweep_addr;
            expect_q(sweep_addr[7:0], "sweep_lo");
            cyc();
        end
        for (int i = 16'hFF00; i <= 16'hFFFF; i++) begin
            sweep_addr = 16'(i);
            addr = sweep_addr;
            expect_q(sweep_addr[7:0], "sweep_hi");
            cyc();
        end

        // Mid-cycle address/data change: only the values at the edge are stored
        wr(16'h2000, 8'h01);
        wr(16'h2001, 8'h02);
        addr  = 16'h2000;
        data  = 8'h77;
        write = 1'b1;
        #6;
        addr  = 16'h2001;
        data  = 8'h88;
        cyc();
        write = 1'b0;
        addr  = 16'h2000;
        expect_q(8'h01, "midcycle_not_stored");
        cyc();
        addr = 16'h2001;
        expect_q(8'h88, "edge_value_stored");
        cyc();

        // Read-during-write on the same address
        wr(16'h0042, 8'h11);
        data  = 8'h22;
        write = 1'b1;
        expect_q(8'h11, "rdw_before_edge");
        cyc();
        write = 1'b0;
        expect_q(8'h22, "rdw_after_edge");
        cyc();

        // Reset retention across a one-cycle pulse
        wr(16'h8000, 8'hC3);
        rst = 1'b1;
        expect_q(8'hC3, "pre_pulse_8000");
        cyc();
        rst = 1'b0;
        expect_q(8'h00, "pulse_zero");
        cyc();
        expect_q(8'hC3, "retained_8000");
        cyc();

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            cyc();
            drain++;
        end
        if (sb_q.size() != 0) begin
            checks_total++;
            $display("FAIL scoreboard_drain: pending=%0d expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_async_single_port_ram
